// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
//   Encodings shared by the memory port arbiter, the CPU control unit and the
//   program loader: FSM state values and requester IDs.
//   No ports; import with "import mem_port_arbiter_pkg::*;".
package mem_port_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  typedef logic req_id_t;

  localparam req_id_t ID_CPU = 1'b0;
  localparam req_id_t ID_LDR = 1'b1;

  // The requester that did not win last time; used to break ties.
  function automatic req_id_t other_id(input req_id_t id);
    return ~id;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles the CPU port, loader port and memory macro signals of the
//   arbiter.
//   Parameters: WIDTH (data width), ADDR_W (address width).
//   Modports:
//     slave  - arbiter view: requests/mem_rdata in, grants/done/rdata/mem_* out
//     master - requester and memory view: the opposite directions
interface mem_port_arbiter_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 32
);

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [WIDTH-1:0]  cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_done;
  logic [WIDTH-1:0]  cpu_rdata;

  logic              ldr_req;
  logic              ldr_we;
  logic [ADDR_W-1:0] ldr_addr;
  logic [WIDTH-1:0]  ldr_wdata;
  logic              ldr_lock;
  logic              ldr_gnt;
  logic              ldr_done;
  logic [WIDTH-1:0]  ldr_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WIDTH-1:0]  mem_wdata;
  logic [WIDTH-1:0]  mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_done, cpu_rdata,
    input  ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_lock,
    output ldr_gnt, ldr_done, ldr_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_done, cpu_rdata,
    output ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_lock,
    input  ldr_gnt, ldr_done, ldr_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/mem_port_arbiter_lat_cnt.sv
// mem_arb_lat_cnt
//   Memory latency counter. It loads MEM_LAT on an issue and then counts down
//   to zero. 'last' flags the cycle in which the memory read data is valid.
//   Ports:
//     clk  - clock
//     rst  - synchronous active-low reset
//     load - issue strobe, loads MEM_LAT
//     last - high while the count equals 1
module mem_arb_lat_cnt #(
  parameter int MEM_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic last
);

  localparam int CW = $clog2(MEM_LAT + 1);

  logic [CW-1:0] cnt;

  // The count rests at zero between accesses. Zero is never a 'last' value.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(MEM_LAT);
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign last = (cnt == CW'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the unified instruction/data memory between the CPU port and the
//   program loader. It arbitrates round-robin with a loader lock, keeps one
//   access outstanding, and returns a done pulse with read data after MEM_LAT
//   cycles.
//   Ports:
//     clk - clock
//     rst - synchronous active-low reset
//     bus - CPU, loader and memory signals (mem_port_arbiter_if.slave)
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int ADDR_W  = 32,
  parameter int MEM_LAT = 1
) (
  input logic clk,
  input logic rst,
  mem_port_arbiter_if.slave bus
);

  state_t  state;
  req_id_t last_gnt;
  req_id_t cur_id;
  req_id_t winner;
  logic    cur_we;
  logic    locked;
  logic    cpu_ok;
  logic    issue;
  logic    done;
  logic    win_we;
  logic    lat_last;
  logic    cpu_done_w;
  logic    ldr_done_w;

  // Winner selection in the IDLE cycle. Reset masks every strobe, so nothing
  // is issued while rst is low even though requests may be present.
  always_comb begin
    cpu_ok = bus.cpu_req && !locked;
    issue  = rst && (state == IDLE) && (cpu_ok || bus.ldr_req);
    if (cpu_ok && bus.ldr_req) begin
      winner = other_id(last_gnt);
    end else if (cpu_ok) begin
      winner = ID_CPU;
    end else begin
      winner = ID_LDR;
    end
    win_we     = (winner == ID_CPU) ? bus.cpu_we : bus.ldr_we;
    done       = rst && (state == WAIT) && lat_last;
    cpu_done_w = done && (cur_id == ID_CPU);
    ldr_done_w = done && (cur_id == ID_LDR);
  end

  // The memory side sees address and data only during the issue cycle.
  // Read data goes only to the owner, and only for reads.
  assign bus.cpu_gnt   = issue && (winner == ID_CPU);
  assign bus.ldr_gnt   = issue && (winner == ID_LDR);
  assign bus.mem_en    = issue;
  assign bus.mem_we    = issue && win_we;
  assign bus.mem_addr  = !issue ? '0 : ((winner == ID_CPU) ? bus.cpu_addr : bus.ldr_addr);
  assign bus.mem_wdata = !issue ? '0 : ((winner == ID_CPU) ? bus.cpu_wdata : bus.ldr_wdata);
  assign bus.cpu_done  = cpu_done_w;
  assign bus.ldr_done  = ldr_done_w;
  assign bus.cpu_rdata = (cpu_done_w && !cur_we) ? bus.mem_rdata : '0;
  assign bus.ldr_rdata = (ldr_done_w && !cur_we) ? bus.mem_rdata : '0;

  // FSM plus the round-robin and lock bookkeeping. The lock holds across the
  // loader's own accesses and clears only in an idle cycle with ldr_lock low.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      last_gnt <= ID_LDR;
      cur_id   <= ID_CPU;
      cur_we   <= 1'b0;
      locked   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (issue) begin
            last_gnt <= winner;
            cur_id   <= winner;
            cur_we   <= win_we;
            state    <= WAIT;
          end
          if (issue && (winner == ID_LDR) && bus.ldr_lock) begin
            locked <= 1'b1;
          end else if (!bus.ldr_lock) begin
            locked <= 1'b0;
          end
        end
        WAIT: begin
          if (lat_last) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  mem_arb_lat_cnt #(
    .MEM_LAT(MEM_LAT)
  ) u_lat_cnt (
    .clk (clk),
    .rst (rst),
    .load(issue),
    .last(lat_last)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Drives two arbiters (MEM_LAT=1 and MEM_LAT=3) from one stimulus sequence.
//   It compares every output, every cycle, against a transaction-level model
//   that tracks issue times, owners and lock state. Directed scenarios come
//   first, followed by a randomized phase for each instance.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int WIDTH  = 32;
  localparam int ADDR_W = 32;
  localparam int LAT0   = 1;
  localparam int LAT1   = 3;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  mem_port_arbiter_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus0 ();
  mem_port_arbiter_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus1 ();

  mem_port_arbiter #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .MEM_LAT(LAT0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0));
  mem_port_arbiter #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .MEM_LAT(LAT1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1));

  // Free-running clock; inputs change on the falling edge.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Stimulus template, applied to the selected instances.
  logic        s_rst, s_cpu_req, s_cpu_we, s_ldr_req, s_ldr_we, s_ldr_lock;
  logic [31:0] s_cpu_addr, s_cpu_wdata, s_ldr_addr, s_ldr_wdata, s_mem_rdata;

  // Inputs each instance actually saw this cycle.
  logic        a_cpu_req [2], a_cpu_we [2], a_ldr_req [2], a_ldr_we [2], a_ldr_lock [2];
  logic [31:0] a_cpu_addr [2], a_cpu_wdata [2], a_ldr_addr [2], a_ldr_wdata [2];

  // Reference model state: whether an access is outstanding, when it was
  // issued, who owns it, and the round-robin and lock memory.
  bit m_busy [2], m_owner [2], m_we [2], m_last [2], m_locked [2];
  int m_issue [2];

  logic        e_cpu_gnt [2], e_ldr_gnt [2], e_cpu_done [2], e_ldr_done [2], e_mem_en [2], e_mem_we [2];
  logic [31:0] e_cpu_rdata [2], e_ldr_rdata [2], e_mem_addr [2], e_mem_wdata [2];

  // Every comparison goes through here.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Predict this cycle's outputs from the arbitration rules, then advance.
  task automatic modelStep(input int d, input int lat);
    bit cw, lw, win;
    e_cpu_gnt[d] = 0; e_ldr_gnt[d] = 0; e_cpu_done[d] = 0; e_ldr_done[d] = 0;
    e_mem_en[d] = 0; e_mem_we[d] = 0; e_mem_addr[d] = 0; e_mem_wdata[d] = 0;
    e_cpu_rdata[d] = 0; e_ldr_rdata[d] = 0;
    if (!rst) begin
      m_busy[d] = 0; m_last[d] = 1; m_locked[d] = 0;
    end else if (m_busy[d]) begin
      if (cyc == m_issue[d] + lat) begin
        if (m_owner[d] == 0) begin
          e_cpu_done[d] = 1; e_cpu_rdata[d] = m_we[d] ? 32'h0 : s_mem_rdata;
        end else begin
          e_ldr_done[d] = 1; e_ldr_rdata[d] = m_we[d] ? 32'h0 : s_mem_rdata;
        end
        m_busy[d] = 0;
      end
    end else begin
      cw = a_cpu_req[d] && !m_locked[d];
      lw = a_ldr_req[d];
      win = (cw && lw) ? !m_last[d] : lw;
      if (cw || lw) begin
        e_mem_en[d] = 1;
        if (!win) begin
          e_cpu_gnt[d] = 1; e_mem_we[d] = a_cpu_we[d];
          e_mem_addr[d] = a_cpu_addr[d]; e_mem_wdata[d] = a_cpu_wdata[d];
        end else begin
          e_ldr_gnt[d] = 1; e_mem_we[d] = a_ldr_we[d];
          e_mem_addr[d] = a_ldr_addr[d]; e_mem_wdata[d] = a_ldr_wdata[d];
        end
        m_busy[d] = 1; m_issue[d] = cyc; m_owner[d] = win; m_we[d] = e_mem_we[d]; m_last[d] = win;
      end
      if ((cw || lw) && win && a_ldr_lock[d]) m_locked[d] = 1;
      else if (!a_ldr_lock[d]) m_locked[d] = 0;
    end
  endtask

  task automatic checkDut(input int d, input logic cg, input logic lg, input logic cd, input logic ld,
                          input logic me, input logic mw, input logic [31:0] cr, input logic [31:0] lr,
                          input logic [31:0] ma, input logic [31:0] mwd);
    string p;
    p = $sformatf("dut%0d@%0d", d, cyc);
    checkOutput({p, " cpu_gnt"},   cg,  e_cpu_gnt[d]);
    checkOutput({p, " ldr_gnt"},   lg,  e_ldr_gnt[d]);
    checkOutput({p, " cpu_done"},  cd,  e_cpu_done[d]);
    checkOutput({p, " ldr_done"},  ld,  e_ldr_done[d]);
    checkOutput({p, " mem_en"},    me,  e_mem_en[d]);
    checkOutput({p, " mem_we"},    mw,  e_mem_we[d]);
    checkOutput({p, " cpu_rdata"}, cr,  e_cpu_rdata[d]);
    checkOutput({p, " ldr_rdata"}, lr,  e_ldr_rdata[d]);
    checkOutput({p, " mem_addr"},  ma,  e_mem_addr[d]);
    checkOutput({p, " mem_wdata"}, mwd, e_mem_wdata[d]);
  endtask

  // One clock cycle: drive on the falling edge, let it settle, compare.
  task automatic applyStimulus(input logic [1:0] sel);
    @(negedge clk);
    rst = s_rst;
    for (int d = 0; d < 2; d++) begin
      a_cpu_req[d]   = sel[d] & s_cpu_req;
      a_cpu_we[d]    = sel[d] & s_cpu_we;
      a_cpu_addr[d]  = sel[d] ? s_cpu_addr  : 32'h0;
      a_cpu_wdata[d] = sel[d] ? s_cpu_wdata : 32'h0;
      a_ldr_req[d]   = sel[d] & s_ldr_req;
      a_ldr_we[d]    = sel[d] & s_ldr_we;
      a_ldr_addr[d]  = sel[d] ? s_ldr_addr  : 32'h0;
      a_ldr_wdata[d] = sel[d] ? s_ldr_wdata : 32'h0;
      a_ldr_lock[d]  = sel[d] & s_ldr_lock;
    end
    bus0.cpu_req = a_cpu_req[0]; bus0.cpu_we = a_cpu_we[0];
    bus0.cpu_addr = a_cpu_addr[0]; bus0.cpu_wdata = a_cpu_wdata[0];
    bus0.ldr_req = a_ldr_req[0]; bus0.ldr_we = a_ldr_we[0]; bus0.ldr_lock = a_ldr_lock[0];
    bus0.ldr_addr = a_ldr_addr[0]; bus0.ldr_wdata = a_ldr_wdata[0];
    bus0.mem_rdata = s_mem_rdata;
    bus1.cpu_req = a_cpu_req[1]; bus1.cpu_we = a_cpu_we[1];
    bus1.cpu_addr = a_cpu_addr[1]; bus1.cpu_wdata = a_cpu_wdata[1];
    bus1.ldr_req = a_ldr_req[1]; bus1.ldr_we = a_ldr_we[1]; bus1.ldr_lock = a_ldr_lock[1];
    bus1.ldr_addr = a_ldr_addr[1]; bus1.ldr_wdata = a_ldr_wdata[1];
    bus1.mem_rdata = s_mem_rdata;
    #1;
    modelStep(0, LAT0);
    modelStep(1, LAT1);
    checkDut(0, bus0.cpu_gnt, bus0.ldr_gnt, bus0.cpu_done, bus0.ldr_done, bus0.mem_en,
             bus0.mem_we, bus0.cpu_rdata, bus0.ldr_rdata, bus0.mem_addr, bus0.mem_wdata);
    checkDut(1, bus1.cpu_gnt, bus1.ldr_gnt, bus1.cpu_done, bus1.ldr_done, bus1.mem_en,
             bus1.mem_we, bus1.cpu_rdata, bus1.ldr_rdata, bus1.mem_addr, bus1.mem_wdata);
    cyc++;
  endtask

  // Directed scenarios, then randomized traffic, then the summary.
  initial begin
    bit q_id [$];
    int q_cyc [$];
    int nldr, ncpu, ndone;
    bit cp, lp;
    logic [1:0] sel;
    int d;

    rst = 1'b0;
    s_rst = 0; s_cpu_req = 0; s_cpu_we = 0; s_cpu_addr = 0; s_cpu_wdata = 0;
    s_ldr_req = 0; s_ldr_we = 0; s_ldr_addr = 0; s_ldr_wdata = 0; s_ldr_lock = 0;
    s_mem_rdata = 0;
    for (int i = 0; i < 2; i++) begin
      m_busy[i] = 0; m_owner[i] = 0; m_we[i] = 0; m_last[i] = 1; m_locked[i] = 0; m_issue[i] = 0;
    end

    // Reset: requests are ignored, then the CPU wins the first tie.
    $display("[TB] reset with both requests held");
    s_cpu_req = 1; s_ldr_req = 1; s_cpu_addr = 32'h4; s_ldr_addr = 32'h8;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(2'b11);
      checkOutput("rst gnt/en dut0", {bus0.cpu_gnt, bus0.ldr_gnt, bus0.mem_en}, 0);
      checkOutput("rst gnt/en dut1", {bus1.cpu_gnt, bus1.ldr_gnt, bus1.mem_en}, 0);
    end
    s_rst = 1;
    applyStimulus(2'b11);
    checkOutput("post-rst cpu_gnt dut0", bus0.cpu_gnt, 1);
    checkOutput("post-rst cpu_gnt dut1", bus1.cpu_gnt, 1);
    s_cpu_req = 0; s_ldr_req = 0;
    applyStimulus(2'b11);
    checkOutput("post-rst cpu_done lat1", bus0.cpu_done, 1);
    applyStimulus(2'b11);
    applyStimulus(2'b11);
    checkOutput("post-rst cpu_done lat3", bus1.cpu_done, 1);

    // CPU read.
    $display("[TB] cpu read");
    s_cpu_req = 1; s_cpu_we = 0; s_cpu_addr = 32'h10; s_mem_rdata = 32'hDEADBEEF;
    applyStimulus(2'b01);
    checkOutput("read cpu_gnt", bus0.cpu_gnt, 1);
    checkOutput("read mem_en", bus0.mem_en, 1);
    checkOutput("read mem_addr", bus0.mem_addr, 32'h10);
    s_cpu_req = 0;
    applyStimulus(2'b01);
    checkOutput("read cpu_done", bus0.cpu_done, 1);
    checkOutput("read cpu_rdata", bus0.cpu_rdata, 32'hDEADBEEF);

    // Lock: three loader writes while the CPU waits, then the CPU gets in.
    $display("[TB] loader lock");
    s_cpu_req = 1; s_cpu_addr = 32'h40;
    s_ldr_req = 1; s_ldr_we = 1; s_ldr_lock = 1; s_ldr_addr = 32'h0; s_ldr_wdata = 32'hA5A5_0000;
    nldr = 0; ncpu = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(2'b01);
      if (bus0.cpu_gnt) ncpu++;
      if (bus0.ldr_gnt) begin
        nldr++;
        s_ldr_addr = s_ldr_addr + 32'h4;
        s_ldr_wdata = s_ldr_wdata + 32'h1;
        if (nldr == 3) s_ldr_req = 0;
      end
    end
    checkOutput("lock cpu grants", ncpu, 0);
    checkOutput("lock ldr grants", nldr, 3);
    s_ldr_lock = 0;
    applyStimulus(2'b01);
    applyStimulus(2'b01);
    checkOutput("unlock cpu_gnt", bus0.cpu_gnt, 1);
    s_cpu_req = 0;
    applyStimulus(2'b01);

    // Round-robin with both requests held over four accesses.
    $display("[TB] tie round-robin");
    s_rst = 0;
    applyStimulus(2'b11);
    s_rst = 1;
    s_cpu_req = 1; s_cpu_we = 0; s_cpu_addr = 32'h100;
    s_ldr_req = 1; s_ldr_we = 1; s_ldr_addr = 32'h200; s_ldr_wdata = 32'h55;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(2'b01);
      if (bus0.cpu_gnt) begin q_id.push_back(0); q_cyc.push_back(cyc); end
      if (bus0.ldr_gnt) begin q_id.push_back(1); q_cyc.push_back(cyc); end
    end
    s_cpu_req = 0; s_ldr_req = 0;
    applyStimulus(2'b01);
    checkOutput("rr grant count", q_id.size(), 4);
    for (int i = 0; i < 4 && i < q_id.size(); i++) begin
      checkOutput($sformatf("rr order %0d", i), q_id[i], i % 2);
      if (i > 0) checkOutput($sformatf("rr spacing %0d", i), q_cyc[i] - q_cyc[i-1], LAT0 + 1);
    end

    // Loader write completion.
    $display("[TB] loader write ack");
    s_ldr_req = 1; s_ldr_we = 1; s_ldr_addr = 32'h20; s_ldr_wdata = 32'h1234; s_mem_rdata = 32'hFFFF_FFFF;
    applyStimulus(2'b01);
    checkOutput("wr ldr_gnt", bus0.ldr_gnt, 1);
    checkOutput("wr mem_we issue", bus0.mem_we, 1);
    checkOutput("wr mem_addr", bus0.mem_addr, 32'h20);
    checkOutput("wr mem_wdata", bus0.mem_wdata, 32'h1234);
    s_ldr_req = 0;
    applyStimulus(2'b01);
    checkOutput("wr mem_we after", bus0.mem_we, 0);
    checkOutput("wr ldr_done", bus0.ldr_done, 1);
    checkOutput("wr ldr_rdata", bus0.ldr_rdata, 0);

    // Reset in the middle of a MEM_LAT=3 access.
    $display("[TB] reset during wait");
    s_cpu_req = 1; s_cpu_we = 0; s_cpu_addr = 32'h30; s_mem_rdata = 32'h0BAD_F00D;
    applyStimulus(2'b10);
    checkOutput("midrst cpu_gnt", bus1.cpu_gnt, 1);
    s_cpu_req = 0; s_rst = 0;
    applyStimulus(2'b10);
    s_rst = 1; s_ldr_req = 1; s_ldr_we = 0; s_ldr_addr = 32'h34;
    applyStimulus(2'b10);
    checkOutput("midrst idle ldr_gnt", bus1.ldr_gnt, 1);
    s_ldr_req = 0;
    ndone = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(2'b10);
      if (bus1.cpu_done) ndone++;
    end
    checkOutput("midrst cpu_done count", ndone, 0);

    // Randomized traffic against each instance, honouring the hold rule.
    $display("[TB] random traffic");
    for (int pass = 0; pass < 2; pass++) begin
      sel = (pass == 0) ? 2'b01 : 2'b10;
      d = pass;
      cp = 0; lp = 0; s_ldr_lock = 0;
      for (int i = 0; i < 200; i++) begin
        if (cp && $urandom_range(0, 15) == 0) cp = 0;
        if (lp && $urandom_range(0, 15) == 0) lp = 0;
        if (!cp && $urandom_range(0, 2) == 0) begin
          cp = 1; s_cpu_we = 1'($urandom); s_cpu_addr = $urandom; s_cpu_wdata = $urandom;
        end
        if (!lp && $urandom_range(0, 2) == 0) begin
          lp = 1; s_ldr_we = 1'($urandom); s_ldr_addr = $urandom; s_ldr_wdata = $urandom;
        end
        if ($urandom_range(0, 7) == 0) s_ldr_lock = ~s_ldr_lock;
        s_cpu_req = cp; s_ldr_req = lp; s_mem_rdata = $urandom;
        applyStimulus(sel);
        if (e_cpu_gnt[d]) cp = 0;
        if (e_ldr_gnt[d]) lp = 0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
